// File: rtl/scroll_display_driver_n.sv
// Multiplexed N-digit seven-segment scroll driver.
// Holds a writable message and time-multiplexes the active-low anodes.
// The window onto the message scrolls automatically or by single steps.
// Everything runs on clk using internal count enables; there are no derived clocks.
module scroll_display_driver_n #(
    parameter int                NUM_DIGITS  = 4,
    parameter int                MSG_CHARS   = 16,
    parameter int                CHAR_W      = 4,
    parameter int                REFRESH_DIV = 50000,
    parameter int                BLANK_CYC   = 500,
    parameter int                SCROLL_DIV  = 83500000,
    parameter logic [CHAR_W-1:0] BLANK_CODE  = CHAR_W'(4'hF)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [$clog2(MSG_CHARS)-1:0]  wr_addr,
    input  logic [CHAR_W-1:0]             wr_data,
    input  logic                          scroll_en,
    input  logic                          dir,
    input  logic                          step,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [CHAR_W-1:0]             char_out,
    output logic                          dp,
    output logic                          scroll_tick,
    output logic                          wrap
);

    localparam int AW = $clog2(MSG_CHARS);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);
    localparam logic [SW-1:0] SCR_LAST  = SW'(SCROLL_DIV - 1);
    localparam logic [AW-1:0] OFF_LAST  = AW'(MSG_CHARS - 1);
    localparam logic [AW:0]   MSG_N     = (AW+1)'(MSG_CHARS);
    localparam logic [AW:0]   REL_TOP   = (AW+1)'(NUM_DIGITS - 1);

    logic [PW-1:0]     r_pre;
    logic [DW-1:0]     r_digit;
    logic [SW-1:0]     r_scr;
    logic [AW-1:0]     r_offset;
    logic [CHAR_W-1:0] r_msg [MSG_CHARS];
    logic [NUM_DIGITS-1:0] r_an;
    logic [CHAR_W-1:0] r_char;
    logic              r_tick;
    logic              r_wrap;

    logic              w_timer_wrap;
    logic              w_req;
    logic [AW-1:0]     w_off_next;
    logic [AW:0]       w_rel;
    logic [AW:0]       w_sum;
    logic [AW-1:0]     w_idx;
    logic              w_addr_ok;

    assign w_timer_wrap = scroll_en && (r_scr == SCR_LAST);
    // A timer wrap and a manual step in the same cycle merge into one request.
    assign w_req        = w_timer_wrap || step;
    assign w_addr_ok    = ({1'b0, wr_addr} < MSG_N);

    // Message index shown on the current digit.
    // The leftmost digit is d = NUM_DIGITS-1 and shows msg[offset].
    // The sum is below 2*MSG_CHARS, so one conditional subtract gives the modulo.
    assign w_rel = REL_TOP - {{(AW+1-DW){1'b0}}, r_digit};
    assign w_sum = {1'b0, r_offset} + w_rel;
    assign w_idx = (w_sum >= MSG_N) ? (w_sum[AW-1:0] - MSG_N[AW-1:0]) : w_sum[AW-1:0];

    // Next offset for one step in the requested direction, wrapping at both ends.
    always_comb begin
        w_off_next = r_offset;
        if (dir == 1'b0) begin
            w_off_next = (r_offset == OFF_LAST) ? '0 : r_offset + AW'(1);
        end else begin
            w_off_next = (r_offset == '0) ? OFF_LAST : r_offset - AW'(1);
        end
    end

    // Refresh prescaler; the digit index advances each time the prescaler wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre   <= '0;
            r_digit <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre   <= '0;
            r_digit <= (r_digit == DIG_LAST) ? '0 : r_digit + DW'(1);
        end else begin
            r_pre   <= r_pre + PW'(1);
        end
    end

    // Scroll interval timer; it is held at zero while auto-scroll is off.
    always_ff @(posedge clk) begin
        if (reset || !scroll_en || w_timer_wrap) begin
            r_scr <= '0;
        end else begin
            r_scr <= r_scr + SW'(1);
        end
    end

    // Scroll offset, plus the one-cycle tick and wrap pulses that follow a step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_offset <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_tick <= w_req;
            r_wrap <= w_req && (w_off_next == '0);
            if (w_req) begin
                r_offset <= w_off_next;
            end
        end
    end

    // Message storage. Reset takes priority over a write; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_CHARS; i++) begin
                r_msg[i] <= BLANK_CODE;
            end
        end else if (wr_en && w_addr_ok) begin
            r_msg[wr_addr] <= wr_data;
        end
    end

    // Registered anode and character outputs.
    // All anodes are held off during the start of each slot to prevent ghosting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an   <= '1;
            r_char <= BLANK_CODE;
        end else begin
            r_char <= r_msg[w_idx];
            r_an   <= '1;
            if (r_pre >= PRE_BLANK) begin
                r_an[r_digit] <= 1'b0;
            end
        end
    end

    assign an          = r_an;
    assign char_out    = r_char;
    assign dp          = 1'b1;
    assign scroll_tick = r_tick;
    assign wrap        = r_wrap;

endmodule

// File: tb/tb_scroll_display_driver_n.sv
// Bench for scroll_display_driver_n.
// It runs directed scenarios and then random traffic.
// Every cycle is checked against a cycle-count reference model.
module tb_scroll_display_driver_n;

    localparam int ND = 4;
    localparam int MC = 6;
    localparam int CW = 4;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int SD = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_addr = '0;
    logic [CW-1:0] wr_data = '0;
    logic          scroll_en = 1'b0;
    logic          dir = 1'b0;
    logic          step = 1'b0;
    logic [ND-1:0] an;
    logic [CW-1:0] char_out;
    logic          dp;
    logic          scroll_tick;
    logic          wrap;

    scroll_display_driver_n #(
        .NUM_DIGITS (ND),
        .MSG_CHARS  (MC),
        .CHAR_W     (CW),
        .REFRESH_DIV(RD),
        .BLANK_CYC  (BC),
        .SCROLL_DIV (SD),
        .BLANK_CODE (4'hF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .scroll_en  (scroll_en),
        .dir        (dir),
        .step       (step),
        .an         (an),
        .char_out   (char_out),
        .dp         (dp),
        .scroll_tick(scroll_tick),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state.
    // m_t counts the clocks since reset release; slot and digit are derived from it arithmetically.
    // m_sc counts consecutive enabled cycles within the current scroll interval.
    int m_msg [MC];
    int m_off = 0;
    int m_t   = 0;
    int m_sc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // One clock: predict the outputs, clock the design, compare, then advance the model.
    task automatic cyc();
        int            p;
        int            d;
        int            noff;
        logic          req;
        logic [ND-1:0] e_an;
        logic [CW-1:0] e_char;
        logic          e_tick;
        logic          e_wrap;
        noff = m_off;
        req  = 1'b0;
        if (reset) begin
            e_an   = 4'hF;
            e_char = 4'hF;
            e_tick = 1'b0;
            e_wrap = 1'b0;
        end else begin
            p      = m_t % RD;
            d      = (m_t / RD) % ND;
            e_an   = (p < BC) ? 4'hF : (4'hF & ~(4'b0001 << d));
            e_char = 4'(m_msg[(m_off + ND - 1 - d) % MC]);
            req    = step || (scroll_en && (m_sc == SD - 1));
            noff   = dir ? (m_off + MC - 1) % MC : (m_off + 1) % MC;
            e_tick = req;
            e_wrap = req && (noff == 0);
        end
        @(posedge clk);
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("char_out", 32'(char_out), 32'(e_char));
        chk("scroll_tick", 32'(scroll_tick), 32'(e_tick));
        chk("wrap", 32'(wrap), 32'(e_wrap));
        chk("dp", 32'(dp), 32'd1);
        if (reset) begin
            for (int i = 0; i < MC; i++) m_msg[i] = 15;
            m_off = 0;
            m_t   = 0;
            m_sc  = 0;
        end else begin
            if (wr_en && (int'(wr_addr) < MC)) m_msg[wr_addr] = int'(wr_data);
            m_t++;
            if (req) m_off = noff;
            m_sc = (scroll_en && (m_sc != SD - 1)) ? m_sc + 1 : 0;
        end
    endtask

    task automatic pulse_step();
        step = 1'b1;
        cyc();
        step = 1'b0;
    endtask

    initial begin
        // 1: two reset cycles, then release with an empty message
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        chk("s1_blank_first", 32'(an), 32'hF);
        cyc();
        chk("s1_an0_first", 32'(an), 32'b1110);
        for (int i = 0; i < 30; i++) cyc();

        // 2: load 1..6 with scrolling off, then watch it stand still
        for (int i = 0; i < MC; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = 4'(i + 1);
            cyc();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 200; i++) cyc();

        // 3: auto-scroll left through one full revolution
        scroll_en = 1'b1;
        dir       = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (i == 9)  chk("s3_tick1", 32'(scroll_tick), 32'd1);
            if (i == 59) chk("s3_wrap6", 32'(wrap), 32'd1);
        end
        scroll_en = 1'b0;
        cyc();

        // 4: manual step right from offset 0, then a step that coincides with a timer wrap
        dir = 1'b1;
        pulse_step();
        chk("s4_tick", 32'(scroll_tick), 32'd1);
        chk("s4_nowrap", 32'(wrap), 32'd0);
        scroll_en = 1'b1;
        for (int i = 0; i < SD - 1; i++) cyc();
        pulse_step();
        scroll_en = 1'b0;
        cyc();
        chk("s4_single", 32'(scroll_tick), 32'd0);
        dir = 1'b0;
        pulse_step();
        cyc();
        pulse_step();
        chk("s4_back_to0", 32'(wrap), 32'd1);

        // 5: an out-of-range write, then a write to the digit that is currently lit
        wr_en   = 1'b1;
        wr_addr = 3'd7;
        wr_data = 4'd0;
        cyc();
        wr_en = 1'b0;
        for (int i = 0; i < 16 && (m_t % 16) != 13; i++) cyc();
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 4'd9;
        cyc();
        wr_en = 1'b0;
        chk("s5_an3", 32'(an), 32'b0111);
        chk("s5_old", 32'(char_out), 32'd1);
        cyc();
        chk("s5_new", 32'(char_out), 32'd9);
        for (int i = 0; i < 20; i++) cyc();

        // 6: reset mid-slot at offset 3, with a write presented in the same cycle
        for (int i = 0; i < 3; i++) begin
            pulse_step();
            cyc();
        end
        cyc();
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 4'd5;
        cyc();
        chk("s6_an", 32'(an), 32'hF);
        chk("s6_char", 32'(char_out), 32'hF);
        reset = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        for (int k = 0; k < 2; k++) begin
            pulse_step();
            for (int i = 0; i < 16; i++) cyc();
        end

        // random traffic
        for (int i = 0; i < 700; i++) begin
            reset     = ($urandom_range(0, 149) == 0);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 4'($urandom_range(0, 15));
            scroll_en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            step      = ($urandom_range(0, 7) == 0);
            cyc();
        end
        reset = 1'b0;
        wr_en = 1'b0;
        step  = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
